// File: rtl/register_file_2r1w.sv
// register_file_2r1w
//   Parametrised register file: one write port, two independent registered
//   read ports, per-byte write enables, write-first bypass, synchronous bulk
//   clear and a sticky out-of-range address flag.
//
// Ports
//   CLK        clock, all state updates on the rising edge
//   RST        asynchronous active-low reset (registers, read outputs, AddrErr)
//   Clear      synchronous clear of every register; wins over a same-cycle write
//   WrEn       write enable
//   WrAddr     write address
//   WrData     write data
//   WrByteEn   byte-lane enables; lane i covers bits [8i+7:8i], top lane may be partial
//   RdEnA/B    read enables
//   RdAddrA/B  read addresses
//   RdDataA/B  registered read data (1-cycle latency, holds when not reading)
//   RdValidA/B registered read valid strobes
//   AddrErr    sticky flag: an out-of-range write or read was seen

module register_file_2r1w #(
  parameter int unsigned reg_WIDTH  = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  localparam int unsigned NUM_BYTES = (reg_WIDTH + 7) / 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Clear,
  input  logic                  WrEn,
  input  logic [ADDR_WIDTH-1:0] WrAddr,
  input  logic [reg_WIDTH-1:0]  WrData,
  input  logic [NUM_BYTES-1:0]  WrByteEn,
  input  logic                  RdEnA,
  input  logic [ADDR_WIDTH-1:0] RdAddrA,
  output logic [reg_WIDTH-1:0]  RdDataA,
  output logic                  RdValidA,
  input  logic                  RdEnB,
  input  logic [ADDR_WIDTH-1:0] RdAddrB,
  output logic [reg_WIDTH-1:0]  RdDataB,
  output logic                  RdValidB,
  output logic                  AddrErr
);

  logic [reg_WIDTH-1:0] regs [DEPTH];

  // Expand byte-lane enables into a per-bit mask; the top lane is clipped
  // naturally because only bits below reg_WIDTH exist.
  logic [reg_WIDTH-1:0] wrMask;
  for (genvar b = 0; b < reg_WIDTH; b++) begin : gen_mask
    assign wrMask[b] = WrByteEn[b / 8];
  end

  logic wrInRange, rdInRangeA, rdInRangeB;
  logic wrCommit;
  logic bypassA, bypassB;
  logic [reg_WIDTH-1:0] oldA, oldB;
  logic [reg_WIDTH-1:0] nextA, nextB;
  logic addrErrNext;

  // Widen before comparing so the check stays meaningful when DEPTH fills
  // the whole address space.
  assign wrInRange  = 32'(WrAddr)  < DEPTH;
  assign rdInRangeA = 32'(RdAddrA) < DEPTH;
  assign rdInRangeB = 32'(RdAddrB) < DEPTH;

  // Clear discards a same-cycle write, so it also suppresses the bypass.
  assign wrCommit = WrEn && wrInRange && !Clear;
  assign bypassA  = wrCommit && (RdAddrA == WrAddr);
  assign bypassB  = wrCommit && (RdAddrB == WrAddr);

  // Read muxes built by address compare, so out-of-range addresses never
  // index past the array.
  always_comb begin
    oldA = '0;
    oldB = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (RdAddrA == ADDR_WIDTH'(i)) oldA = regs[i];
      if (RdAddrB == ADDR_WIDTH'(i)) oldB = regs[i];
    end
  end

  always_comb begin
    nextA = '0;
    if (rdInRangeA) begin
      nextA = bypassA ? ((WrData & wrMask) | (oldA & ~wrMask)) : oldA;
    end
  end

  always_comb begin
    nextB = '0;
    if (rdInRangeB) begin
      nextB = bypassB ? ((WrData & wrMask) | (oldB & ~wrMask)) : oldB;
    end
  end

  assign addrErrNext = AddrErr
                     | (WrEn  && !wrInRange)
                     | (RdEnA && !rdInRangeA)
                     | (RdEnB && !rdInRangeB);

  // Storage
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (Clear) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wrCommit) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (WrAddr == ADDR_WIDTH'(i)) begin
          regs[i] <= (WrData & wrMask) | (regs[i] & ~wrMask);
        end
      end
    end
  end

  // Read port A
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RdDataA  <= '0;
      RdValidA <= 1'b0;
    end else begin
      RdValidA <= RdEnA;
      if (RdEnA) RdDataA <= nextA;
    end
  end

  // Read port B
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      RdDataB  <= '0;
      RdValidB <= 1'b0;
    end else begin
      RdValidB <= RdEnB;
      if (RdEnB) RdDataB <= nextB;
    end
  end

  // Sticky error flag; only reset clears it, Clear leaves it alone.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      AddrErr <= 1'b0;
    end else begin
      AddrErr <= addrErrNext;
    end
  end

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
Parametrised register file with one write port and two independent read ports. Supports a configurable width and depth, per-byte write enables, and registered reads with a valid strobe. Same-cycle write-to-read bypass, a synchronous bulk clear, and out-of-range address detection are included. Intended as the general-purpose register storage for datapath blocks that need two operands per cycle.

Parameters:
reg_WIDTH, 16, data width in bits (>=1; need not be a multiple of 8)
DEPTH, 8, number of registers (2..2^ADDR_WIDTH)
ADDR_WIDTH, 3, address width in bits
NUM_BYTES, (reg_WIDTH+7)/8, derived, not overridden; byte-lane count, top lane may be partial

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  asynchronous active-low reset
Clear  input  1  synchronous clear of all registers
WrEn  input  1  write enable
WrAddr  input  ADDR_WIDTH  write address
WrData  input  reg_WIDTH  write data
WrByteEn  input  NUM_BYTES  byte-lane enables; lane i covers bits [8i+7:8i], clipped to reg_WIDTH
RdEnA  input  1  read enable, port A
RdAddrA  input  ADDR_WIDTH  read address, port A
RdDataA  output  reg_WIDTH  registered read data, port A
RdValidA  output  1  port A data valid
RdEnB  input  1  read enable, port B
RdAddrB  input  ADDR_WIDTH  read address, port B
RdDataB  output  reg_WIDTH  registered read data, port B
RdValidB  output  1  port B data valid
AddrErr  output  1  sticky flag: out-of-range access seen

Behaviour:
- Reset (RST=0, asynchronous, any time, including mid-access): all DEPTH registers, RdDataA/B, RdValidA/B and AddrErr go to 0 immediately. Reset dominates every other input. The first edge after release behaves normally.
- Write: on a rising edge with WrEn=1 and WrAddr<DEPTH, each lane with WrByteEn[i]=1 takes WrData bits. Lanes with WrByteEn[i]=0 keep their value. WrByteEn=0 is a legal no-op write.
- Read latency is 1 cycle. On a rising edge with RdEnX=1, RdDataX <= the contents of RdAddrX and RdValidX <= 1.
- With RdEnX=0: RdValidX <= 0 and RdDataX holds its last value.
- Bypass (write-first): if WrEn=1 and RdEnX=1 in the same cycle with RdAddrX==WrAddr<DEPTH, RdDataX receives the merged value (new lanes where WrByteEn=1, old lanes otherwise). Both ports bypass independently. Both ports may read the same address.
- Out of range (address>=DEPTH, only possible when DEPTH<2^ADDR_WIDTH):
  - write: ignored, no register changes; sets AddrErr.
  - read: RdDataX <= 0 and RdValidX <= 1; sets AddrErr.
- AddrErr is sticky. Only RST clears it; Clear does not.
- Clear=1 at an edge: all registers <= 0, and Clear takes priority over a write in the same cycle (the write is discarded). A read in the same cycle returns the pre-clear contents (no bypass of the clear). RdDataX/RdValidX follow the normal read rules.
- No state machine beyond the storage. All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: hold RST=0 with RdEnA=1, RdAddrA=7, then release → after 1 edge RdDataA=0, RdValidA=1; AddrErr=0.
- Full write/read: write 6000,840,900,720,210,1150,620,310 to addresses 7..0 with WrByteEn=2'b11; read A=5, B=1 in the same cycle → next edge RdDataA=900, RdDataB=620, both valid; with RdEn dropped, valids go 0 and data holds.
- Byte enable + bypass: reg 3=0x1234; write WrData=0xABCD, WrByteEn=2'b01 to addr 3 while RdEnA=1, RdAddrA=3 → RdDataA=0x12CD the same edge; a later read of addr 3 also returns 0x12CD.
- Out of range with DEPTH=6: write 0x5555 to addr 6 → no register changes, AddrErr=1; read addr 7 → RdData=0, RdValid=1; AddrErr stays 1 through Clear and drops only on RST.
- Clear vs write: Clear=1 and WrEn=1 (addr 2, 0xFFFF) with RdEnB=1, RdAddrB=2 (old value 1150) → RdDataB=1150; the next read of addr 2 returns 0.
- Async reset mid-access: assert RST low between edges during back-to-back writes → outputs go 0 without waiting for an edge; all registers read 0 afterwards.
